// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the 8-bit tri-state data bus. The driver side and
// every receive-end capture FIFO use this package.
//   BUS_WIDTH     - data bus width in bits
//   CAPTURE_DEPTH - default number of entries in a receive-end FIFO
//   bus_word_t    - one bus word
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_WIDTH     = 8;
    localparam int CAPTURE_DEPTH = 4;

    typedef logic [BUS_WIDTH-1:0] bus_word_t;

endpackage : bus_pkg

// File: rtl/bus_capture_mem.sv
// ---------------------------------------------------------------------------
// bus_capture_mem
// A DEPTH x WIDTH register array for the capture FIFO. It has one
// synchronous write port and one asynchronous read port. The array is not
// reset.
// Ports:
//   clk   - system clock
//   we    - write enable; wdata is stored at waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - array contents at raddr, combinational
// ---------------------------------------------------------------------------
module bus_capture_mem
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int DEPTH = CAPTURE_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : bus_capture_mem

// File: rtl/bus_capture_fifo.sv
// ---------------------------------------------------------------------------
// bus_capture_fifo
// The receive end of the shared data bus. When a source drives the bus and
// this destination is selected, the module samples the bus. Captured bytes
// go into a first-word-fall-through FIFO, and the downstream datapath reads
// them with a valid/ready handshake. If a capture arrives while the FIFO is
// full and no pop happens in the same cycle, the byte is dropped and the
// sticky overflow flag is set.
// Ports:
//   clk       - system clock
//   reset     - synchronous active-high reset
//   bus_in    - shared data bus at this destination
//   bus_drive - a source is driving bus_in this cycle
//   sel       - this destination is addressed
//   out_data  - head-of-FIFO byte (0 while empty)
//   out_valid - FIFO non-empty
//   out_ready - consumer accepts out_data this cycle
//   count     - occupancy, 0..DEPTH
//   full      - count == DEPTH
//   overflow  - sticky, set when a capture is dropped
// ---------------------------------------------------------------------------
module bus_capture_fifo
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int DEPTH = CAPTURE_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       bus_in,
    input  logic                   bus_drive,
    input  logic                   sel,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W:0]   count_q;
    logic             overflow_q;
    logic [WIDTH-1:0] rdata;

    logic cap;
    logic pop;
    logic wr_en;

    // While bus_drive is low, bus_in is undefined. Gating on bus_drive here
    // keeps those values out of storage and out of all state.
    assign cap   = bus_drive & sel;
    assign pop   = out_valid & out_ready;
    // When full, a write is still allowed if the head leaves in the same
    // cycle. The freed slot is the one the write pointer points at.
    assign wr_en = cap & (~full | pop);

    assign count     = count_q;
    assign full      = (count_q == COUNT_FULL);
    assign out_valid = (count_q != '0);
    assign overflow  = overflow_q;
    // Mask the storage read while empty so that out_data resets to 0 even
    // though the array itself is not reset.
    assign out_data  = out_valid ? rdata : '0;

    bus_capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en & ~reset),
        .waddr (wptr),
        .wdata (bus_in),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr       <= '0;
            wptr       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            if (cap & full & ~pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule : bus_capture_fifo

// File: tb/tb_bus_capture_fifo.sv
// ---------------------------------------------------------------------------
// tb_bus_capture_fifo
// Directed testbench for bus_capture_fifo. Expected values are written out
// by hand in each check.
// ---------------------------------------------------------------------------
module tb_bus_capture_fifo;
    import bus_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    bus_word_t bus_in;
    logic      bus_drive;
    logic      sel;
    bus_word_t out_data;
    logic      out_valid;
    logic      out_ready;
    logic [2:0] count;
    logic      full;
    logic      overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_capture_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .bus_in    (bus_in),
        .bus_drive (bus_drive),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic d, input logic s, input logic [7:0] b, input logic r);
        bus_drive = d;
        sel       = s;
        bus_in    = b;
        out_ready = r;
    endtask

    // Wait for the next rising edge, then return 1 time unit later.
    // All checks and input changes happen at that point.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick;
        reset = 1'b0;
    endtask

    task automatic fill_11_44;
        logic [7:0] v;
        for (int i = 1; i <= 4; i++) begin
            v = 8'(i * 8'h11);
            drive(1'b1, 1'b1, v, 1'b0);
            tick;
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Each drain entry is checked before the edge that pops it.
    task automatic drain4(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_pop%0d", tag, i), 32'(out_data), exp[i]);
            tick;
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk({tag, "_empty_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick;
        tick;
        reset = 1'b0;
        chk_empty("rst");
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Bus not driven: bus_in must not be captured, even with sel high.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 8'(8'h3C ^ (i * 8'h5A)), 1'b0);
            tick;
        end
        chk("idle_count", 32'(count), 32'd0);

        // Capture only happens when both bus_drive and sel are high.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'hA5, 1'b0);
            tick;
        end
        chk("gate_nosel_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'hA5, 1'b0);
            tick;
        end
        chk("gate_nodrv_count", 32'(count), 32'd0);
        drive(1'b1, 1'b1, 8'hA5, 1'b0);
        tick;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("gate_valid", 32'(out_valid), 32'd1);
        chk("gate_data", 32'(out_data), 32'hA5);
        chk("gate_count", 32'(count), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk_empty("gate_drained");

        // Fill to full, then try one more capture, which must be dropped.
        fill_11_44;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_head", 32'(out_data), 32'h11);
        drive(1'b1, 1'b1, 8'h55, 1'b0);
        tick;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        drain4("ovf_drain", 32'h11, 32'h22, 32'h33, 32'h44);
        tick;
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_reset;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Capture and pop together while full.
        fill_11_44;
        drive(1'b1, 1'b1, 8'h66, 1'b1);
        tick;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("simfull_count", 32'(count), 32'd4);
        chk("simfull_ovf", 32'(overflow), 32'd0);
        chk("simfull_head", 32'(out_data), 32'h22);
        drain4("simfull_drain", 32'h22, 32'h33, 32'h44, 32'h66);

        // Capture and pop together at count 1. Over 11 writes, the pointers
        // wrap more than twice.
        drive(1'b1, 1'b1, 8'hF0, 1'b0);
        tick;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 8'(i), 1'b1);
            chk($sformatf("wrap_head%0d", i), 32'(out_data), (i == 0) ? 32'hF0 : 32'(i - 1));
            tick;
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("wrap_count", 32'(count), 32'd1);
        chk("wrap_valid", 32'(out_valid), 32'd1);
        chk("wrap_last", 32'(out_data), 32'h09);

        // A reset in the middle of operation; the capture in the same cycle
        // is ignored.
        drive(1'b1, 1'b1, 8'hA0, 1'b0);
        tick;
        drive(1'b1, 1'b1, 8'hA1, 1'b0);
        tick;
        chk("pre_rst_count", 32'(count), 32'd3);
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'hB0, 1'b1);
        tick;
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk_empty("midrst");
        chk("midrst_ovf", 32'(overflow), 32'd0);
        tick;
        chk("midrst_hold_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bus_capture_fifo
